// File: rtl/whack_pkg.sv
// Shared constants and helpers for the whack-switch front-end.
// The module parameters of the blocks below default to these values.
package whack_pkg;

    localparam int unsigned NUM_SW              = 8;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned HIT_TOTAL_W         = 8;

    localparam logic [HIT_TOTAL_W-1:0] HIT_TOTAL_MAX = 8'd255;

    // Saturating add. The running total never wraps past HIT_TOTAL_MAX.
    function automatic logic [HIT_TOTAL_W-1:0] sat_add(
        input logic [HIT_TOTAL_W-1:0] acc,
        input logic [HIT_TOTAL_W-1:0] inc
    );
        logic [HIT_TOTAL_W:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[HIT_TOTAL_W] ? HIT_TOTAL_MAX : sum[HIT_TOTAL_W-1:0];
    endfunction

endpackage

// File: rtl/sw_debounce_channel.sv
// One switch channel: 2-flop synchroniser, hold-time debounce counter and stable level.
// flip_o is high for the single cycle in which the stable level is about to change.
module sw_debounce_channel
    import whack_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic flip_o
);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    always_comb begin
        s1_d     = raw_i;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        flip     = 1'b0;
        // Any cycle where s2 matches the stable level restarts the hold count.
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
                flip     = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign flip_o   = flip;

endmodule

// File: rtl/switch_hit_detector.sv
// Whack-switch front-end: per-channel debounce, game-window gating of flip events into
// one-cycle hit pulses, and a saturating per-game hit total.
module switch_hit_detector
    import whack_pkg::*;
#(
    parameter int unsigned N_SW            = NUM_SW,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                   CLK100MHZ,
    input  logic                   RST_BTN,
    input  logic [N_SW-1:0]        switches,
    input  logic                   gamestart,
    input  logic                   gameend,
    output logic [N_SW-1:0]        positionhit,
    output logic [N_SW-1:0]        stable_sw,
    output logic                   game_active,
    output logic [HIT_TOTAL_W-1:0] hit_total
);

    logic [N_SW-1:0]        flip;
    logic [N_SW-1:0]        gated;
    logic [HIT_TOTAL_W-1:0] pulse_cnt;

    logic [N_SW-1:0]        positionhit_q, positionhit_d;
    logic                   game_active_q, game_active_d;
    logic [HIT_TOTAL_W-1:0] hit_total_q, hit_total_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        sw_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_i    (CLK100MHZ),
            .rst_ni   (RST_BTN),
            .raw_i    (switches[i]),
            .stable_o (stable_sw[i]),
            .flip_o   (flip[i])
        );
    end

    always_comb begin
        gated     = flip & {N_SW{game_active_q}};
        pulse_cnt = '0;
        for (int i = 0; i < N_SW; i++) begin
            pulse_cnt = pulse_cnt + HIT_TOTAL_W'(gated[i]);
        end

        positionhit_d = gated;

        // gameend dominates a coincident gamestart.
        game_active_d = game_active_q;
        if (gameend) begin
            game_active_d = 1'b0;
        end else if (gamestart) begin
            game_active_d = 1'b1;
        end

        if (gamestart) begin
            hit_total_d = pulse_cnt;
        end else begin
            hit_total_d = sat_add(hit_total_q, pulse_cnt);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!RST_BTN) begin
            positionhit_q <= '0;
            game_active_q <= 1'b0;
            hit_total_q   <= '0;
        end else begin
            positionhit_q <= positionhit_d;
            game_active_q <= game_active_d;
            hit_total_q   <= hit_total_d;
        end
    end

    assign positionhit = positionhit_q;
    assign game_active = game_active_q;
    assign hit_total   = hit_total_q;

endmodule
